// File: rtl/timer_pkg.sv
// Shared state codes, time limits and action encoding for the countdown timer and its
// downstream buzzer, light and display decoders.
package timer_pkg;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t SET   = 3'd1;
    localparam state_t RUN   = 3'd2;
    localparam state_t PAUSE = 3'd3;
    localparam state_t ALARM = 3'd4;

    localparam logic [5:0] MAX_SEC = 6'd59;
    localparam logic [5:0] MAX_MIN = 6'd59;

    // One decoded button action per cycle, already priority-resolved.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_STOP,
        ACT_START,
        ACT_MODE,
        ACT_LOAD,
        ACT_MIN,
        ACT_SEC
    } action_e;

    function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] lim);
        return (v == lim) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Per-button 2-FF synchroniser plus stable-level filter; rise pulses for one cycle when a
// new high level is accepted, 2+DB_CYCLES cycles after the raw input changes.
module sw_debounce #(
    parameter int DB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, rise_q;
    logic [CW-1:0] cnt_q;
    logic          settle;

    assign settle = (sync2_q != level_q) && (cnt_q == CW'(DB_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            rise_q  <= settle && sync2_q;
            // Any return to the accepted level restarts the stability count.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (settle) begin
                cnt_q   <= '0;
                level_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/timer_state_controller.sv
// Countdown-timer control stage: debounced buttons drive the IDLE/SET/RUN/PAUSE/ALARM FSM,
// the mm:ss registers and the 1 Hz prescaler; every output comes straight from a flop.
module timer_state_controller
    import timer_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int DB_CYCLES = 500_000,
    parameter int ALARM_SEC = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sw2,
    input  logic               sw3,
    input  logic               sw4,
    input  logic               sw5,
    input  logic               sw6,
    input  logic               sw7,
    input  logic [9:0]         dipSwitch,
    output logic [STATE_W-1:0] state,
    output logic [5:0]         min_o,
    output logic [5:0]         sec_o,
    output logic               tick_1hz
);

    localparam int PW = $clog2(CLK_HZ + 1);
    localparam int AW = $clog2(ALARM_SEC + 1);

    logic [5:0]    sw_raw, sw_level, sw_rise, sw_press;
    action_e       act;
    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic          tick_q, tick_d;
    logic [5:0]    min_q, min_d, sec_q, sec_d;
    logic          counting, wrap, time_zero, last_sec;

    assign sw_raw = {sw7, sw6, sw5, sw4, sw3, sw2};

    for (genvar i = 0; i < 6; i++) begin : g_db
        sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (sw_raw[i]),
            .level(sw_level[i]),
            .rise (sw_rise[i])
        );
    end

    assign sw_press  = sw_rise & sw_level;
    assign counting  = (state_q == RUN) || (state_q == ALARM);
    assign wrap      = counting && (presc_q == PW'(CLK_HZ - 1));
    assign time_zero = (min_q == 6'd0) && (sec_q == 6'd0);
    assign last_sec  = (min_q == 6'd0) && (sec_q == 6'd1);

    // Priority sw3 > sw2 > sw4 > sw5 > sw6 > sw7.
    always_comb begin
        act = ACT_NONE;
        if      (sw_press[1]) act = ACT_STOP;
        else if (sw_press[0]) act = ACT_START;
        else if (sw_press[2]) act = ACT_MODE;
        else if (sw_press[3]) act = ACT_LOAD;
        else if (sw_press[4]) act = ACT_MIN;
        else if (sw_press[5]) act = ACT_SEC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (act == ACT_START && !time_zero) state_d = RUN;
                else if (act == ACT_MODE)           state_d = SET;
            end
            SET: begin
                if (act == ACT_STOP)                     state_d = IDLE;
                else if (act == ACT_START && !time_zero) state_d = RUN;
                else if (act == ACT_MODE)                state_d = IDLE;
            end
            RUN: begin
                // Reaching 00:00 outranks a pause press on the same edge.
                if (act == ACT_STOP)         state_d = IDLE;
                else if (wrap && last_sec)   state_d = ALARM;
                else if (act == ACT_START)   state_d = PAUSE;
            end
            PAUSE: begin
                if (act == ACT_STOP)       state_d = IDLE;
                else if (act == ACT_START) state_d = RUN;
            end
            ALARM: begin
                if (act == ACT_STOP || act == ACT_START)                 state_d = IDLE;
                else if (wrap && alarm_cnt_q == AW'(ALARM_SEC - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        state    = state_q;
        min_o    = min_q;
        sec_o    = sec_q;
        tick_1hz = tick_q;
    end

    // Prescaler restarts on a fresh RUN and on ALARM entry; PAUSE simply stops counting.
    always_comb begin
        presc_d     = presc_q;
        alarm_cnt_d = alarm_cnt_q;
        tick_d      = wrap;
        if (state_d == ALARM && state_q != ALARM) begin
            presc_d     = '0;
            alarm_cnt_d = '0;
        end else if (state_d == RUN && (state_q == IDLE || state_q == SET)) begin
            presc_d = '0;
        end else if (counting) begin
            presc_d = wrap ? '0 : presc_q + PW'(1);
            if (state_q == ALARM && wrap) alarm_cnt_d = alarm_cnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            alarm_cnt_q <= '0;
            tick_q      <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            alarm_cnt_q <= alarm_cnt_d;
            tick_q      <= tick_d;
        end
    end

    always_comb begin
        min_d = min_q;
        sec_d = sec_q;
        if (act == ACT_STOP) begin
            min_d = 6'd0;
            sec_d = 6'd0;
        end else if (state_q == SET) begin
            case (act)
                ACT_LOAD: begin
                    min_d = {2'b00, dipSwitch[9:6]};
                    sec_d = (dipSwitch[5:0] > MAX_SEC) ? MAX_SEC : dipSwitch[5:0];
                end
                ACT_MIN: min_d = inc_wrap(min_q, MAX_MIN);
                ACT_SEC: sec_d = inc_wrap(sec_q, MAX_SEC);
                default: ;
            endcase
        end else if (state_q == RUN && wrap) begin
            if (sec_q == 6'd0) begin
                sec_d = MAX_SEC;
                min_d = min_q - 6'd1;
            end else begin
                sec_d = sec_q - 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= 6'd0;
            sec_q <= 6'd0;
        end else begin
            min_q <= min_d;
            sec_q <= sec_d;
        end
    end

endmodule

// File: tb/tb_timer_state_controller.sv
// Directed bench for timer_state_controller with CLK_HZ=10, DB_CYCLES=4, ALARM_SEC=3.
module tb_timer_state_controller;
    import timer_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [5:0]   sw;
    logic [9:0]   dip;
    logic [2:0]   state;
    logic [5:0]   min_o, sec_o;
    logic         tick_1hz;

    int n_cmp = 0;
    int n_bad = 0;
    int run_samples = 0;

    typedef struct {
        int         btn;
        logic [9:0] dip;
        int         st;
        int         mn;
        int         sc;
    } vec_t;

    vec_t vecs[16];

    timer_state_controller #(.CLK_HZ(10), .DB_CYCLES(4), .ALARM_SEC(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw2      (sw[0]),
        .sw3      (sw[1]),
        .sw4      (sw[2]),
        .sw5      (sw[3]),
        .sw6      (sw[4]),
        .sw7      (sw[5]),
        .dipSwitch(dip),
        .state    (state),
        .min_o    (min_o),
        .sec_o    (sec_o),
        .tick_1hz (tick_1hz)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (state == RUN) run_samples++;
    endtask

    // Pulse a button long enough to pass the filter, then release it fully.
    task automatic press(input int b);
        sw[b-2] = 1'b1;
        repeat (7) step();
        sw[b-2] = 1'b0;
        repeat (8) step();
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget,
                              output int cycles, output int ticks, output bit ok);
        cycles = 0;
        ticks  = 0;
        ok     = 1'b0;
        while (cycles < budget && !ok) begin
            step();
            cycles++;
            if (tick_1hz) ticks++;
            if (state == target) ok = 1'b1;
        end
    endtask

    task automatic wait_tick(input int budget, output bit ok);
        int c = 0;
        ok = 1'b0;
        while (c < budget && !ok) begin
            step();
            c++;
            if (tick_1hz) ok = 1'b1;
        end
    endtask

    initial begin
        int  cyc, tks, snap;
        bit  ok;

        vecs[0]  = '{2, 10'b0000_000000, IDLE, 0, 0};
        vecs[1]  = '{4, 10'b0000_000000, SET,  0, 0};
        vecs[2]  = '{2, 10'b0000_000000, SET,  0, 0};
        vecs[3]  = '{5, 10'b0001_000101, SET,  1, 5};
        vecs[4]  = '{6, 10'b0001_000101, SET,  2, 5};
        vecs[5]  = '{7, 10'b0001_000101, SET,  2, 6};
        vecs[6]  = '{4, 10'b0001_000101, IDLE, 2, 6};
        vecs[7]  = '{5, 10'b1111_111111, IDLE, 2, 6};
        vecs[8]  = '{4, 10'b1111_111111, SET,  2, 6};
        vecs[9]  = '{3, 10'b1111_111111, IDLE, 0, 0};
        vecs[10] = '{4, 10'b1111_111111, SET,  0, 0};
        vecs[11] = '{5, 10'b1111_111111, SET,  15, 59};
        vecs[12] = '{7, 10'b1111_111111, SET,  15, 0};
        vecs[13] = '{5, 10'b0000_111100, SET,  0, 59};
        vecs[14] = '{7, 10'b0000_111100, SET,  0, 0};
        vecs[15] = '{5, 10'b0001_000101, SET,  1, 5};

        sw    = '0;
        dip   = '0;
        rst_n = 1'b0;
        #2;
        check("reset_state", state, IDLE);
        check("reset_min", min_o, 0);
        check("reset_sec", sec_o, 0);
        check("reset_tick", tick_1hz, 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 16; i++) begin
            dip = vecs[i].dip;
            press(vecs[i].btn);
            check($sformatf("vec%0d_state", i), state, vecs[i].st);
            check($sformatf("vec%0d_min", i), min_o, vecs[i].mn);
            check($sformatf("vec%0d_sec", i), sec_o, vecs[i].sc);
        end

        // 01:05 countdown to ALARM, then self-expiry.
        sw[0] = 1'b1;
        wait_state(RUN, 12, cyc, tks, ok);
        check("run_entry", ok, 1);
        sw[0] = 1'b0;
        wait_state(ALARM, 700, cyc, tks, ok);
        check("alarm_reached", ok, 1);
        check("alarm_cycles", cyc, 650);
        check("run_ticks", tks, 65);
        check("alarm_min", min_o, 0);
        check("alarm_sec", sec_o, 0);
        wait_state(IDLE, 60, cyc, tks, ok);
        check("alarm_expire", ok, 1);
        check("alarm_expire_cycles", cyc, 30);
        check("alarm_ticks", tks, 3);
        press(2);
        check("idle_zero_start", state, IDLE);

        // SET-mode limits: minute wrap and held button.
        press(4);
        dip = 10'b1111_111111;
        press(5);
        press(7);
        for (int i = 0; i < 44; i++) press(6);
        check("min_at_59", min_o, 59);
        press(6);
        check("min_wrap", min_o, 0);
        sw[4] = 1'b1;
        repeat (40) step();
        sw[4] = 1'b0;
        repeat (8) step();
        check("hold_one_pulse", min_o, 1);
        dip = 10'b0010_111011;
        press(5);
        press(7);
        check("sec_wrap_sec", sec_o, 0);
        check("sec_wrap_min", min_o, 2);

        // Pause at 00:29 and resume from the held prescaler.
        dip = 10'b0000_011110;
        press(5);
        check("load_30", sec_o, 30);
        sw[0] = 1'b1;
        wait_state(RUN, 12, cyc, tks, ok);
        sw[0] = 1'b0;
        wait_tick(15, ok);
        check("first_tick", ok, 1);
        check("first_tick_sec", sec_o, 29);
        snap = run_samples;
        press(2);
        check("pause_state", state, PAUSE);
        tks = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tick_1hz) tks++;
        end
        check("pause_no_tick", tks, 0);
        check("pause_sec_held", sec_o, 29);
        check("pause_min_held", min_o, 0);
        sw[0] = 1'b1;
        wait_state(RUN, 12, cyc, tks, ok);
        check("resume", ok, 1);
        sw[0] = 1'b0;
        wait_tick(15, ok);
        check("resume_tick", ok, 1);
        check("resume_run_cycles", run_samples - snap, 10);
        check("resume_sec", sec_o, 28);

        // Short glitch ignored, then simultaneous stop+start.
        sw[0] = 1'b1;
        repeat (3) step();
        sw[0] = 1'b0;
        repeat (12) step();
        check("glitch_ignored", state, RUN);
        sw[0] = 1'b1;
        sw[1] = 1'b1;
        repeat (7) step();
        check("stop_wins_state", state, IDLE);
        check("stop_wins_min", min_o, 0);
        check("stop_wins_sec", sec_o, 0);
        sw[0] = 1'b0;
        sw[1] = 1'b0;
        repeat (8) step();

        // Stop during ALARM acts on the edge after the pulse.
        press(4);
        press(7);
        sw[0] = 1'b1;
        wait_state(RUN, 12, cyc, tks, ok);
        sw[0] = 1'b0;
        wait_state(ALARM, 15, cyc, tks, ok);
        check("short_alarm_cycles", cyc, 10);
        sw[1] = 1'b1;
        repeat (6) step();
        check("stop_alarm_before", state, ALARM);
        step();
        check("stop_alarm_after", state, IDLE);
        sw[1] = 1'b0;
        repeat (8) step();

        // Asynchronous reset mid-RUN, then a full-latency first press.
        press(4);
        dip = 10'b0001_000101;
        press(5);
        sw[0] = 1'b1;
        wait_state(RUN, 12, cyc, tks, ok);
        sw[0] = 1'b0;
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_state", state, IDLE);
        check("async_rst_min", min_o, 0);
        check("async_rst_sec", sec_o, 0);
        step();
        rst_n = 1'b1;
        sw[2] = 1'b1;
        repeat (6) step();
        check("post_rst_early", state, IDLE);
        step();
        check("post_rst_set", state, SET);
        sw[2] = 1'b0;
        repeat (8) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
